// File: rtl/sd_resp_rx.sv
// SD CMD-line response receiver: 48-bit (R1/R3/R6/R7) and 136-bit (R2) frames with CRC7 and framing checks.
// Defining SD_RESP_INDEX_CHECK_EN adds the command-index comparator that drives index_err.
module sd_resp_rx #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         rx_en,
  input  logic         long_resp,
  input  logic         skip_crc,
  input  logic [5:0]   expected_index,
  input  logic         sd_cmd,
  output logic         busy,
  output logic         done,
  output logic [126:0] resp,
  output logic         crc_err,
  output logic         frame_err,
  output logic         timeout,
  output logic         index_err
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_START = 2'd1;
  localparam logic [1:0] RECEIVE    = 2'd2;
  localparam logic [1:0] FINISH     = 2'd3;

  localparam logic [CNT_W-1:0] SHORT_TOP   = CNT_W'(47);
  localparam logic [CNT_W-1:0] LONG_TOP    = CNT_W'(135);
  localparam logic [CNT_W-1:0] SHORT_TRANS = CNT_W'(46);
  localparam logic [CNT_W-1:0] LONG_TRANS  = CNT_W'(134);
  localparam logic [CNT_W-1:0] LONG_BODY   = CNT_W'(127);
  localparam logic [CNT_W-1:0] SHORT_BODY  = CNT_W'(45);
  localparam logic [CNT_W-1:0] CRC_LOW     = CNT_W'(8);
  localparam logic [CNT_W-1:0] CRC_FIELD   = CNT_W'(7);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] bit_idx;
  logic [6:0]       crc;
  logic [6:0]       crc_rx;
  logic [6:0]       crc_base;
  logic [6:0]       crc_next;
  logic             crc_fb;
  logic             long_q;
  logic             skip_q;
  logic             in_crc;
  logic             in_crc_field;
  logic             in_payload;
  logic             at_trans;

  // In RECEIVE, cnt holds the index of the bit sampled last; the bit on the line now is cnt-1.
  assign bit_idx      = cnt - CNT_W'(1);
  assign in_crc       = (bit_idx >= CRC_LOW);
  assign in_crc_field = (bit_idx != '0) && (bit_idx <= CRC_FIELD);
  assign in_payload   = long_q ? ((bit_idx != '0) && (bit_idx <= LONG_BODY))
                               : ((bit_idx >= CRC_LOW) && (bit_idx <= SHORT_BODY));
  assign at_trans     = (bit_idx == (long_q ? LONG_TRANS : SHORT_TRANS));

  // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    crc_base = crc;
    if (long_q && bit_idx == LONG_BODY) crc_base = 7'd0;
    crc_fb   = crc_base[6] ^ sd_cmd;
    crc_next = {crc_base[5:0], 1'b0} ^ {3'b000, crc_fb, 2'b00, crc_fb};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      crc       <= '0;
      crc_rx    <= '0;
      long_q    <= 1'b0;
      skip_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      resp      <= '0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_en) begin
            state     <= WAIT_START;
            busy      <= 1'b1;
            long_q    <= long_resp;
            skip_q    <= skip_crc;
            cnt       <= '0;
            crc       <= '0;
            resp      <= '0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        WAIT_START: begin
          // A start bit on the expiry cycle still wins over the timeout.
          if (!sd_cmd) begin
            state <= RECEIVE;
            cnt   <= long_q ? LONG_TOP : SHORT_TOP;
            crc   <= '0;
          end else if (cnt == TO_LAST) begin
            state   <= FINISH;
            timeout <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RECEIVE: begin
          if (cnt != '0) begin
            cnt <= bit_idx;
            if (in_crc)       crc    <= crc_next;
            if (in_crc_field) crc_rx <= {crc_rx[5:0], sd_cmd};
            if (in_payload)   resp   <= {resp[125:0], sd_cmd};
            if (at_trans && sd_cmd)           frame_err <= 1'b1;
            if (bit_idx == '0 && !sd_cmd)     frame_err <= 1'b1;
          end else begin
            // End bit was captured on the previous edge; publish the verdict now.
            state   <= FINISH;
            done    <= 1'b1;
            busy    <= 1'b0;
            crc_err <= !skip_q && (crc_rx != crc);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SD_RESP_INDEX_CHECK_EN
  logic [5:0] exp_idx_q;
  logic [5:0] idx_rx;
  logic       in_index;

  // Short frames carry the index in bits 45..40; R2 carries 6'b111111 in bits 133..128.
  assign in_index = long_q ? ((bit_idx >= CNT_W'(128)) && (bit_idx <= CNT_W'(133)))
                           : ((bit_idx >= CNT_W'(40))  && (bit_idx <= CNT_W'(45)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_idx_q <= '0;
      idx_rx    <= '0;
      index_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_en) begin
            exp_idx_q <= (long_resp || skip_crc) ? 6'h3F : expected_index;
            index_err <= 1'b0;
          end
        end
        RECEIVE: begin
          if (cnt != '0) begin
            if (in_index) idx_rx <= {idx_rx[4:0], sd_cmd};
          end else begin
            index_err <= (idx_rx != exp_idx_q);
          end
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_expected_index;
  assign unused_expected_index = ^expected_index;
  assign index_err             = 1'b0;
`endif

endmodule

// File: tb/tb_sd_resp_rx.sv
// Scoreboard bench for sd_resp_rx: stimulus pushes expected completions, a monitor checks every done pulse.
module tb_sd_resp_rx;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         rx_en = 1'b0;
  logic         long_resp = 1'b0;
  logic         skip_crc = 1'b0;
  logic [5:0]   expected_index = 6'd0;
  logic         sd_cmd = 1'b1;
  logic         busy;
  logic         done;
  logic [126:0] resp;
  logic         crc_err;
  logic         frame_err;
  logic         timeout;
  logic         index_err;

`ifdef SD_RESP_INDEX_CHECK_EN
  localparam bit IDX_EN = 1'b1;
`else
  localparam bit IDX_EN = 1'b0;
`endif

  sd_resp_rx #(.TIMEOUT(64), .CNT_W(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_en          (rx_en),
    .long_resp      (long_resp),
    .skip_crc       (skip_crc),
    .expected_index (expected_index),
    .sd_cmd         (sd_cmd),
    .busy           (busy),
    .done           (done),
    .resp           (resp),
    .crc_err        (crc_err),
    .frame_err      (frame_err),
    .timeout        (timeout),
    .index_err      (index_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        tag;
    logic [126:0] resp;
    logic         crc_err;
    logic         frame_err;
    logic         timeout;
    logic         index_err;
    int unsigned  cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [126:0] act, input logic [126:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [135:0] bits, input int hi, input int lo);
    logic [6:0] c = 7'd0;
    logic       fb;
    for (int i = hi; i >= lo; i--) begin
      fb = c[6] ^ bits[i];
      c  = {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    end
    return c;
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {126'd0, done}, 127'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_resp"},      resp,      mon_e.resp);
        check({mon_e.tag, "_crc_err"},   crc_err,   mon_e.crc_err);
        check({mon_e.tag, "_frame_err"}, frame_err, mon_e.frame_err);
        check({mon_e.tag, "_timeout"},   timeout,   mon_e.timeout);
        check({mon_e.tag, "_index_err"}, index_err, mon_e.index_err);
        check({mon_e.tag, "_busy_low"},  busy,      1'b0);
        check({mon_e.tag, "_latency"},   cyc,       mon_e.cyc);
      end
    end
  end

  task automatic wait_drain(input string tag, input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, (sb.size() == 0), 1'b1);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic arm(input logic lng, input logic skp, input logic [5:0] eidx);
    @(posedge clk); #1;
    rx_en = 1'b1; long_resp = lng; skip_crc = skp; expected_index = eidx;
    @(posedge clk); #1;
    // Scramble the mode inputs after acceptance: the block must use its latched copies.
    rx_en = 1'b0; long_resp = ~lng; skip_crc = ~skp; expected_index = ~eidx;
  endtask

  task automatic send(input string tag, input logic lng, input logic skp, input logic [5:0] eidx,
                      input logic [135:0] frame, input int gap, input logic [126:0] e_resp,
                      input logic e_crc, input logic e_frm, input logic e_idx);
    exp_t e;
    int   len;
    len = lng ? 136 : 48;
    arm(lng, skp, eidx);
    check({tag, "_busy_armed"}, busy, 1'b1);
    repeat (gap) begin @(posedge clk); #1; end
    e.tag = tag; e.resp = e_resp; e.crc_err = e_crc; e.frame_err = e_frm;
    e.timeout = 1'b0; e.index_err = e_idx;
    e.cyc = cyc + 1 + len;
    sb.push_back(e);
    for (int i = len - 1; i >= 0; i--) begin
      sd_cmd = frame[i];
      @(posedge clk); #1;
    end
    sd_cmd = 1'b1;
    wait_drain(tag, 50);
  endtask

  logic [135:0] f;
  logic [119:0] cid;
  exp_t         te;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_resp", resp, 127'd0);
    check("rst_crc_err", crc_err, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_index_err", index_err, 1'b0);
    reset_n = 1'b1;

    // CMD activity while idle must not start a reception.
    repeat (2) @(posedge clk);
    #1 sd_cmd = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("idle_ignore_busy", busy, 1'b0);
    sd_cmd = 1'b1;
    repeat (3) @(posedge clk);

    // Clean R1: CMD17 response 0x11 00000900, CRC 0x33.
    f = '0; f[47:0] = {8'h11, 32'h0000_0900, 7'h33, 1'b1};
    send("r1", 1'b0, 1'b0, 6'd17, f, 5, {89'd0, 38'h11_0000_0900}, 1'b0, 1'b0, 1'b0);

    // Corrupted CRC field, then the same frame with the CRC check bypassed (R3 style).
    f = '0; f[47:0] = {8'h11, 32'h0000_0900, 7'h32, 1'b1};
    send("r1_badcrc", 1'b0, 1'b0, 6'd17, f, 3, {89'd0, 38'h11_0000_0900}, 1'b1, 1'b0, 1'b0);
    send("r1_skipcrc", 1'b0, 1'b1, 6'd17, f, 3, {89'd0, 38'h11_0000_0900}, 1'b0, 1'b0, IDX_EN);

    // End bit 0: framing error only.
    f = '0; f[47:0] = {8'h11, 32'h0000_0900, 7'h33, 1'b0};
    send("r1_endbit", 1'b0, 1'b0, 6'd17, f, 2, {89'd0, 38'h11_0000_0900}, 1'b0, 1'b1, 1'b0);

    // Transmission bit 1: framing error, and the CRC over bit 46 no longer matches 0x33.
    f = '0; f[47:0] = {8'h51, 32'h0000_0900, 7'h33, 1'b1};
    send("r1_transbit", 1'b0, 1'b0, 6'd17, f, 2, {89'd0, 38'h11_0000_0900}, 1'b1, 1'b1, 1'b0);

    // No start bit: timeout after exactly 64 cycles in WAIT_START.
    arm(1'b0, 1'b0, 6'd17);
    check("timeout_busy_armed", busy, 1'b1);
    te.tag = "timeout"; te.resp = '0; te.crc_err = 1'b0; te.frame_err = 1'b0;
    te.timeout = 1'b1; te.index_err = 1'b0; te.cyc = cyc + 64;
    sb.push_back(te);
    wait_drain("timeout", 100);

    // R2 with a CID whose internal CRC7 covers bits 127..8.
    cid = 120'h035344_53553136_47801234_56780162;
    f = {8'h3F, cid, 7'h00, 1'b1};
    f[7:1] = crc7(f, 127, 8);
    send("r2", 1'b1, 1'b0, 6'd2, f, 4, f[127:1], 1'b0, 1'b0, 1'b0);

    // Index 18 received while 17 expected (flags index_err only with the comparator built in).
    f = '0; f[47:8] = {2'b00, 6'd18, 32'h0000_0900};
    f[7:1] = crc7(f, 47, 8); f[0] = 1'b1;
    send("r1_index", 1'b0, 1'b0, 6'd17, f, 1, {89'd0, 6'd18, 32'h0000_0900}, 1'b0, 1'b0, IDX_EN);

    // Reset asserted while frame bit 20 is on the line: everything clears, no done.
    f = '0; f[47:0] = {8'h11, 32'h0000_0900, 7'h33, 1'b1};
    arm(1'b0, 1'b0, 6'd17);
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 47; i > 20; i--) begin
      sd_cmd = f[i];
      @(posedge clk); #1;
    end
    sd_cmd = f[20];
    check("mid_busy", busy, 1'b1);
    check("mid_resp_nonzero", (resp != '0), 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_resp", resp, 127'd0);
    check("mid_rst_flags", {crc_err, frame_err, timeout, index_err}, 4'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    sd_cmd = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    send("r1_after_rst", 1'b0, 1'b0, 6'd17, f, 5, {89'd0, 38'h11_0000_0900}, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
